alu_rr_arbiter: RTL
===================

Name: alu_rr_arbiter

Overview:
- Shares one ALU32Bit instance between two requesters: requester 0 (pipeline EX stage) and requester 1 (auxiliary/debug engine).
- Round-robin grant; one operation in flight at a time.
- Registers the operands into the ALU, captures the combinational result, and returns it with a valid/ready handshake to the requester that issued it.
- Sits between the requesters and the ALU; the ALU's ALUControl, A, B and ALUResult connect directly to the Alu* ports.

Parameters:
- DATA_W, 32, operand/result width.
- OP_W, 5, opcode width (matches ALUControl).
- MAX_OP, 9, highest legal opcode (5'b01001, XOR).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req0Valid  in  1  requester 0 has an operation.
- Req0Ready  out  1  requester 0 accepted this cycle when Valid&Ready.
- Req0Op  in  OP_W  requester 0 opcode.
- Req0A, Req0B  in  DATA_W  requester 0 operands.
- Resp0Valid  out  1  result available for requester 0.
- Resp0Ready  in  1  requester 0 consumes the result.
- Resp0Result  out  DATA_W  result for requester 0.
- Req1Valid, Req1Ready, Req1Op, Req1A, Req1B, Resp1Valid, Resp1Ready, Resp1Result: same as above, for requester 1.
- AluOp  out  OP_W  to ALU ALUControl.
- AluA, AluB  out  DATA_W  to ALU A and B.
- AluResult  in  DATA_W  from ALU ALUResult (combinational).
- OpErr  out  1  sticky illegal-opcode flag.

Behaviour:
- States: IDLE, EXEC, RESP. On Reset, from any state:
  - state=IDLE;
  - priority pointer Prio=0;
  - AluOp=0, AluA=0, AluB=0;
  - both RespResult=0, both RespValid=0;
  - OpErr=0;
  - Owner=0.
  - An in-flight operation is discarded; no response is produced.
- IDLE, grant (combinational from the Valids and Prio):
  - Only one Valid high: grant it.
  - Both Valid high: grant the requester equal to Prio.
  - ReqXReady=1 only for the granted requester, and only in IDLE. Ready is 0 in every other state.
- IDLE, on accept (ReqXValid & ReqXReady):
  - Latch Op/A/B into the AluOp/AluA/AluB registers; set Owner=X.
  - Set Prio = ~X, so the other requester wins the next tie.
  - Next state EXEC.
- EXEC (exactly 1 cycle):
  - Alu* outputs are stable from the registers.
  - At the end of the cycle, latch AluResult into RespXResult for X=Owner. Next state RESP.
- RESP:
  - RespXValid=1 for X=Owner; the other requester's RespValid=0.
  - Hold Valid and Result until RespXReady=1, then go to IDLE.
  - Requesters are not accepted during the RESP cycle.
- Latency:
  - Accept at cycle T; RespValid high at T+2.
  - Minimum 3 cycles per operation (T accept, T+1 EXEC, T+2 RESP with Ready=1, T+3 next accept).
- Alu* outputs hold their last latched values outside EXEC. They change only on accept.
- RespXResult holds its value after consumption until overwritten by the next operation owned by X.
- Valid with no accept: a requester must keep Valid/Op/A/B stable until accepted. The block does not sample them except on accept.
- Arithmetic: the block never modifies operands or the result; width is DATA_W throughout.
- Boundary conditions:
  - Both requesters valid forever: strict alternation 0,1,0,1…
  - Response backpressure: a stalled RespReady blocks all new accepts.

Optional Feature:
- Macro: ALU_OPCHK_EN.
- Defined:
  - On accept, Op > MAX_OP is illegal.
  - Skip EXEC: go IDLE→RESP directly; RespXResult=0; set OpErr=1, sticky until Reset.
  - Alu* registers are not updated for an illegal op.
  - Latency for an illegal op is RespValid at T+1.
- Undefined:
  - All opcodes go through EXEC unchanged; the ALU's default case yields 0.
  - OpErr is tied to 0.

Test Plan:
- Reset, then Req0 op=0 (add), A=5, B=7, Resp0Ready=1 → Req0Ready at T, AluOp=0/AluA=5/AluB=7 at T+1, Resp0Valid=1 and Resp0Result=12 at T+2, back in IDLE at T+3.
- Req0 and Req1 both valid continuously: Req0 op=1, A=10, B=3; Req1 op=8, A=0xFF, B=0x0F → grants alternate 0,1,0,…; Resp0Result=7 and Resp1Result=0x0F; no response misrouted.
- Req1 op=5 (slt), A=0xFFFFFFFF, B=1; Resp1Ready held 0 for 4 cycles → Resp1Valid=1 and Resp1Result=1 held stable; Req0Ready=0 throughout; accept resumes the cycle after Ready=1.
- Assert Reset during EXEC (op=2, A=6, B=7) → next cycle IDLE, all outputs 0, no Resp0Valid ever; a following request behaves as if fresh, with Prio=0.
- ALU_OPCHK_EN defined: Req0 op=5'b10000 → Resp0Valid at T+1 with Result=0, OpErr=1 and it stays 1. Undefined: same stimulus gives RespValid at T+2, Result=0, OpErr=0.
- Req1 alone valid while Prio=0 → granted immediately, no wait cycle.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Optional ALU_OPCHK_EN: opcodes above MAX_OP skip the ALU, return 0 and set sticky OpErr.
module alu_rr_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5,
    parameter int MAX_OP = 9
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0Valid,
    output logic              Req0Ready,
    input  logic [OP_W-1:0]   Req0Op,
    input  logic [DATA_W-1:0] Req0A,
    input  logic [DATA_W-1:0] Req0B,
    output logic              Resp0Valid,
    input  logic              Resp0Ready,
    output logic [DATA_W-1:0] Resp0Result,
    input  logic              Req1Valid,
    output logic              Req1Ready,
    input  logic [OP_W-1:0]   Req1Op,
    input  logic [DATA_W-1:0] Req1A,
    input  logic [DATA_W-1:0] Req1B,
    output logic              Resp1Valid,
    input  logic              Resp1Ready,
    output logic [DATA_W-1:0] Resp1Result,
    output logic [OP_W-1:0]   AluOp,
    output logic [DATA_W-1:0] AluA,
    output logic [DATA_W-1:0] AluB,
    input  logic [DATA_W-1:0] AluResult,
    output logic              OpErr
);

`ifdef ALU_OPCHK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif
    localparam logic [OP_W-1:0] MAX_OP_V = OP_W'(MAX_OP);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    logic              prio;
    logic              owner;
    logic              gnt0, gnt1, acc, acc_id, illegal, resp_done;
    logic [OP_W-1:0]   acc_op;
    logic [DATA_W-1:0] acc_a, acc_b;

    // Prio names the requester that wins a tie; a lone requester never waits.
    always_comb begin
        gnt0      = Req0Valid && (!Req1Valid || !prio);
        gnt1      = Req1Valid && (!Req0Valid || prio);
        Req0Ready = (state == IDLE) && gnt0;
        Req1Ready = (state == IDLE) && gnt1;
        acc       = Req0Ready || Req1Ready;
        acc_id    = Req1Ready;
        acc_op    = acc_id ? Req1Op : Req0Op;
        acc_a     = acc_id ? Req1A  : Req0A;
        acc_b     = acc_id ? Req1B  : Req0B;
        illegal   = OPCHK && (acc_op > MAX_OP_V);
        resp_done = owner ? Resp1Ready : Resp0Ready;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            prio        <= 1'b0;
            owner       <= 1'b0;
            AluOp       <= '0;
            AluA        <= '0;
            AluB        <= '0;
            Resp0Result <= '0;
            Resp1Result <= '0;
            Resp0Valid  <= 1'b0;
            Resp1Valid  <= 1'b0;
            OpErr       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (acc) begin
                    owner <= acc_id;
                    prio  <= !acc_id;
                    if (illegal) begin
                        // Illegal ops bypass the ALU and leave its operand registers untouched.
                        OpErr <= 1'b1;
                        state <= RESP;
                        if (acc_id) begin
                            Resp1Result <= '0;
                            Resp1Valid  <= 1'b1;
                        end else begin
                            Resp0Result <= '0;
                            Resp0Valid  <= 1'b1;
                        end
                    end else begin
                        AluOp <= acc_op;
                        AluA  <= acc_a;
                        AluB  <= acc_b;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    state <= RESP;
                    if (owner) begin
                        Resp1Result <= AluResult;
                        Resp1Valid  <= 1'b1;
                    end else begin
                        Resp0Result <= AluResult;
                        Resp0Valid  <= 1'b1;
                    end
                end
                RESP: if (resp_done) begin
                    state      <= IDLE;
                    Resp0Valid <= 1'b0;
                    Resp1Valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
